// File: rtl/pmod_dac_sequencer_pkg.sv
// Shared state encoding and DAC constants for the PMOD DAC sample sequencer.
package pmod_dac_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRIME    = 2'd1,
    ST_PLAY     = 2'd2,
    ST_UNDERRUN = 2'd3
  } state_t;

  localparam logic [7:0] DAC_MIDSCALE = 8'h80;

endpackage

// File: rtl/pmod_dac_sequencer_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; rd_dat shows the head with zero latency.
// Pushes while full and pops while empty are ignored; flush outranks push and pop.
module pmod_dac_sequencer_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

  assign rd_dat = mem[rd_ptr];
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);

endmodule

// File: rtl/pmod_dac_sequencer.sv
// Paces buffered 8-bit samples to the DAC, one per CLKS_PER_SAMPLE clocks once PRIME_LEVEL are queued.
// Producer sees o_wr_ready = !full outside IDLE; an empty buffer at a tick holds o_byte and flags underrun.
module pmod_dac_sequencer
  import pmod_dac_sequencer_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = 3125,
  parameter int FIFO_DEPTH      = 16,
  parameter int PRIME_LEVEL     = 8
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_L,
  input  logic                          i_enable,
  input  logic [7:0]                    i_wr_data,
  input  logic                          i_wr_valid,
  output logic                          o_wr_ready,
  input  logic                          i_clr_underrun,
  output logic [7:0]                    o_byte,
  output logic                          o_sample_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_underrun,
  output logic                          o_busy
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          push;
  logic          pop;
  logic [7:0]    head_dat;
  logic [LW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  pmod_dac_sequencer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (i_Clk),
    .rst_n  (i_Rst_L),
    .flush  (!i_enable),
    .push   (push),
    .pop    (pop),
    .wr_dat (i_wr_data),
    .rd_dat (head_dat),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!i_enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:               state_nxt = ST_PRIME;
        ST_PRIME, ST_UNDERRUN: if (fifo_count >= PRIME_LVL) state_nxt = ST_PLAY;
        ST_PLAY:               if (tick && fifo_empty) state_nxt = ST_UNDERRUN;
        default:               state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy     = (state != ST_IDLE);
    o_wr_ready = (state != ST_IDLE) && !fifo_full;
    tick       = (state == ST_PLAY) && (cnt == CNT_LAST);
  end

  assign push    = i_wr_valid && o_wr_ready;
  // Disable flushes on the same edge, so a tick then must neither pop nor strobe.
  assign pop     = tick && !fifo_empty && i_enable;
  assign o_level = fifo_count;

  // Counter idles at zero outside PLAY, which gives the load-0 on entry for free.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt             <= '0;
      o_byte          <= DAC_MIDSCALE;
      o_sample_strobe <= 1'b0;
      o_underrun      <= 1'b0;
    end else begin
      if (!i_enable || state != ST_PLAY || tick) cnt <= '0;
      else                                        cnt <= cnt + 1'b1;

      if (!i_enable) o_byte <= DAC_MIDSCALE;
      else if (pop)  o_byte <= head_dat;

      o_sample_strobe <= pop;

      if (!i_enable)                o_underrun <= 1'b0;
      else if (tick && fifo_empty)  o_underrun <= 1'b1;
      else if (i_clr_underrun)      o_underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pmod_dac_sequencer.sv
// Directed bench for pmod_dac_sequencer (4 clocks/sample, depth 16, prime 8) with a sample scoreboard.
module tb_pmod_dac_sequencer;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L;
  logic       i_enable;
  logic [7:0] i_wr_data;
  logic       i_wr_valid;
  logic       o_wr_ready;
  logic       i_clr_underrun;
  logic [7:0] o_byte;
  logic       o_sample_strobe;
  logic [4:0] o_level;
  logic       o_underrun;
  logic       o_busy;

  pmod_dac_sequencer #(
    .CLKS_PER_SAMPLE (4),
    .FIFO_DEPTH      (16),
    .PRIME_LEVEL     (8)
  ) dut (
    .i_Clk           (i_Clk),
    .i_Rst_L         (i_Rst_L),
    .i_enable        (i_enable),
    .i_wr_data       (i_wr_data),
    .i_wr_valid      (i_wr_valid),
    .o_wr_ready      (o_wr_ready),
    .i_clr_underrun  (i_clr_underrun),
    .o_byte          (o_byte),
    .o_sample_strobe (o_sample_strobe),
    .o_level         (o_level),
    .o_underrun      (o_underrun),
    .o_busy          (o_busy)
  );

  always #5 i_Clk = ~i_Clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  bit         en_state = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict acceptance, advance, then score strobes and occupancy.
  task automatic cyc();
    logic       en;
    logic       acc;
    logic [7:0] wd;
    logic [7:0] e;
    en  = i_enable;
    wd  = i_wr_data;
    acc = i_wr_valid && en_state && (exp_q.size() < 16);
    chk("wr_ready", o_wr_ready, en_state && (exp_q.size() < 16));
    @(posedge i_Clk);
    #1;
    if (!en) exp_q.delete();
    else if (acc) exp_q.push_back(wd);
    en_state = en;
    if (o_sample_strobe) begin
      chk("strobe_has_data", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sample", o_byte, e);
      end
    end
    chk("level", o_level, exp_q.size());
  endtask

  // From PRIME/UNDERRUN with an empty buffer: queue 8, expect one sample every 4 clocks.
  task automatic play8(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = 8'(base + 8'(i));
      cyc();
    end
    i_wr_valid = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      cyc();
      chk("play_strobe", o_sample_strobe, (k >= 5) && ((k - 5) % 4 == 0));
    end
    chk("play_last_byte", o_byte, 8'(base + 8'd7));
    chk("play_drained", o_level, 0);
  endtask

  initial begin
    i_Rst_L        = 1'b0;
    i_enable       = 1'b0;
    i_wr_data      = 8'h00;
    i_wr_valid     = 1'b0;
    i_clr_underrun = 1'b0;

    // 1: reset values, then release with enable low
    #12;
    chk("rst_byte", o_byte, 8'h80);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_wr_ready, 0);
    chk("rst_level", o_level, 0);
    chk("rst_strobe", o_sample_strobe, 0);
    chk("rst_underrun", o_underrun, 0);
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    repeat (3) cyc();
    chk("idle_byte", o_byte, 8'h80);
    chk("idle_busy", o_busy, 0);

    // 2: prime and play
    i_enable = 1'b1;
    cyc();
    chk("prime_busy", o_busy, 1);
    play8(8'h10);

    // 3: underrun; set wins over a simultaneous clear; clear pulse; refill
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("pre_underrun", o_underrun, 0);
    end
    i_clr_underrun = 1'b1;
    cyc();
    i_clr_underrun = 1'b0;
    chk("underrun_set", o_underrun, 1);
    chk("underrun_nostrobe", o_sample_strobe, 0);
    chk("underrun_hold", o_byte, 8'h17);
    cyc();
    chk("underrun_sticky", o_underrun, 1);
    i_clr_underrun = 1'b1;
    cyc();
    i_clr_underrun = 1'b0;
    chk("underrun_clr", o_underrun, 0);
    play8(8'h20);
    repeat (4) cyc();
    chk("underrun_again", o_underrun, 1);

    // 4: disable flushes, then backpressure at full
    i_enable = 1'b0;
    cyc();
    chk("dis_busy", o_busy, 0);
    chk("dis_byte", o_byte, 8'h80);
    chk("dis_underrun", o_underrun, 0);
    i_enable = 1'b1;
    cyc();
    i_wr_valid = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      i_wr_data = 8'(8'h50 + 8'(k));
      cyc();
      chk("bp_strobe", o_sample_strobe, (k >= 13) && ((k - 13) % 4 == 0));
      if (k == 18) begin
        chk("bp_full_level", o_level, 16);
        chk("bp_full_ready", o_wr_ready, 0);
      end
      if (k == 22) chk("bp_refill", o_level, 16);
    end

    // 5: disable on a tick edge with a write pending
    i_enable  = 1'b0;
    i_wr_data = 8'hEE;
    cyc();
    i_wr_valid = 1'b0;
    chk("dtick_busy", o_busy, 0);
    chk("dtick_level", o_level, 0);
    chk("dtick_byte", o_byte, 8'h80);
    chk("dtick_strobe", o_sample_strobe, 0);
    chk("dtick_underrun", o_underrun, 0);

    // 6: asynchronous reset mid-play, right after a strobe
    i_enable = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = 8'(8'h30 + 8'(i));
      cyc();
    end
    i_wr_valid = 1'b0;
    repeat (5) cyc();
    chk("pre_arst_strobe", o_sample_strobe, 1);
    #2;
    i_Rst_L = 1'b0;
    #1;
    exp_q.delete();
    en_state = 1'b0;
    chk("arst_byte", o_byte, 8'h80);
    chk("arst_strobe", o_sample_strobe, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_level", o_level, 0);
    chk("arst_ready", o_wr_ready, 0);
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    cyc();
    chk("rearm_busy", o_busy, 1);
    play8(8'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
